// File: rtl/systolic_feeder.sv
// systolic_feeder: FIFO-buffered bf16 operand feeder with one-cycle lane-1 skew; FEEDER_BEATCNT_EN enables beat_count
module systolic_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a0,
  input  logic [15:0] in_a1,
  input  logic [15:0] in_b0,
  input  logic [15:0] in_b1,
  input  logic        in_last,
  output logic [15:0] a_out0,
  output logic [15:0] a_out1,
  output logic [15:0] b_out0,
  output logic [15:0] b_out1,
  output logic        feed_valid,
  output logic        clear_acc,
  output logic        done,
  output logic [7:0]  beat_count
);
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [64:0] mem_q [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] occ_q;
  logic push, pop, empty;
  logic [64:0] head;
  logic [15:0] a0_d, a1_d, b0_d, b1_d, sa_q, sb_q, sa_d, sb_d;
  logic fv_d, clr_d, done_d;
  assign in_ready = occ_q < 3'd4;
  assign empty = occ_q == 3'd0;
  assign push = in_valid && in_ready;
  assign pop = (state_q == FEED) && !empty;
  assign head = mem_q[rptr_q];
  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= {in_a0, in_a1, in_b0, in_b1, in_last};
  // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q <= '0;
    end else begin
      wptr_q <= wptr_q + 2'(push);
      rptr_q <= rptr_q + 2'(pop);
      occ_q <= occ_q + 3'(push) - 3'(pop);
    end
  // next state and next registered outputs
  always_comb begin
    state_d = state_q;
    a0_d = '0;
    a1_d = '0;
    b0_d = '0;
    b1_d = '0;
    sa_d = '0;
    sb_d = '0;
    fv_d = 1'b0;
    clr_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        state_d = FEED;
        clr_d = 1'b1;
      end
      FEED: begin
        a1_d = sa_q;
        b1_d = sb_q;
        if (pop) begin
          a0_d = head[64:49];
          sa_d = head[48:33];
          b0_d = head[32:17];
          sb_d = head[16:1];
          fv_d = 1'b1;
          state_d = head[0] ? FLUSH : FEED;
        end
      end
      FLUSH: begin
        a1_d = sa_q;
        b1_d = sb_q;
        done_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, skew and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      a_out0 <= '0;
      a_out1 <= '0;
      b_out0 <= '0;
      b_out1 <= '0;
      feed_valid <= 1'b0;
      clear_acc <= 1'b0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      a_out0 <= a0_d;
      a_out1 <= a1_d;
      b_out0 <= b0_d;
      b_out1 <= b1_d;
      feed_valid <= fv_d;
      clear_acc <= clr_d;
      done <= done_d;
    end
`ifdef FEEDER_BEATCNT_EN
  logic [7:0] cnt_q;
  // beats issued this job, cleared as the job starts and saturating at 255
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_d) cnt_q <= '0;
    else if (pop && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  assign beat_count = cnt_q;
`else
  assign beat_count = '0;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed and random checks of systolic_feeder against a queue-based model
module tb_systolic_feeder;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0;
  logic [15:0] in_a0 = 0, in_a1 = 0, in_b0 = 0, in_b1 = 0;
  logic in_ready, feed_valid, clear_acc, done;
  logic [15:0] a_out0, a_out1, b_out0, b_out1;
  logic [7:0] beat_count;
  systolic_feeder dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1), .in_last(in_last),
    .a_out0(a_out0), .a_out1(a_out1), .b_out0(b_out0), .b_out1(b_out1),
    .feed_valid(feed_valid), .clear_acc(clear_acc), .done(done), .beat_count(beat_count));
  always #5 clk = ~clk;
  typedef struct packed {logic [15:0] a0, a1, b0, b1; logic last;} beat_t;
  beat_t mq[$];
  int ph;
  logic [15:0] ea0, ea1, eb0, eb1, sa, sb;
  logic efv, eclr, ed;
  int ecnt;
  int errs = 0, checks = 0;
  bit acc;
  int nclr, ndn, nfv;
  logic [15:0] la0[$], la1[$];
  bit lfv[$], ldn[$], lclr[$], lrdy[$];
  logic [7:0] lbc[$];
`ifdef FEEDER_BEATCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s @%0t observed=%0h expected=%0h", t, $time, o, e);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    ph = 0;
    {ea0, ea1, eb0, eb1, sa, sb} = '0;
    {efv, eclr, ed} = '0;
    ecnt = 0;
  endtask
  task automatic cmp(input string t);
    chk({t, " a_out0"}, 32'(a_out0), 32'(ea0));
    chk({t, " a_out1"}, 32'(a_out1), 32'(ea1));
    chk({t, " b_out0"}, 32'(b_out0), 32'(eb0));
    chk({t, " b_out1"}, 32'(b_out1), 32'(eb1));
    chk({t, " feed_valid"}, 32'(feed_valid), 32'(efv));
    chk({t, " clear_acc"}, 32'(clear_acc), 32'(eclr));
    chk({t, " done"}, 32'(done), 32'(ed));
    chk({t, " in_ready"}, 32'(in_ready), 32'(mq.size() < 4));
    chk({t, " beat_count"}, 32'(beat_count), CNT_ON ? 32'(ecnt) : 32'd0);
  endtask
  task automatic clr_log();
    la0.delete(); la1.delete(); lfv.delete(); ldn.delete(); lclr.delete(); lrdy.delete(); lbc.delete();
    nclr = 0; ndn = 0; nfv = 0;
  endtask
  task automatic cyc();
    beat_t e;
    bit push, pop;
    int n;
    n = mq.size();
    push = !rst && in_valid && n < 4;
    acc = push;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      pop = ph == 1 && n > 0;
      e = '0;
      if (pop) e = mq.pop_front();
      eclr = 0;
      ed = 0;
      case (ph)
        0: begin
          {ea0, ea1, eb0, eb1, efv} = '0;
          if (n > 0) begin eclr = 1; ecnt = 0; ph = 1; end
        end
        1: begin
          ea1 = sa; eb1 = sb;
          ea0 = e.a0; eb0 = e.b0; efv = pop; sa = e.a1; sb = e.b1;
          if (pop && ecnt < 255) ecnt++;
          if (pop && e.last) ph = 2;
        end
        2: begin
          ea1 = sa; eb1 = sb; ea0 = 0; eb0 = 0; efv = 0; sa = 0; sb = 0; ed = 1; ph = 3;
        end
        default: begin
          {ea0, ea1, eb0, eb1, efv} = '0; ph = 0;
        end
      endcase
      if (push) mq.push_back({in_a0, in_a1, in_b0, in_b1, in_last});
    end
    @(negedge clk);
    cmp("cycle");
    la0.push_back(a_out0); la1.push_back(a_out1); lfv.push_back(feed_valid);
    ldn.push_back(done); lclr.push_back(clear_acc); lrdy.push_back(in_ready); lbc.push_back(beat_count);
    nclr += int'(clear_acc); ndn += int'(done); nfv += int'(feed_valid);
  endtask
  task automatic drv(input bit v, input bit l, input logic [15:0] a0, a1, b0, b1);
    in_valid = v; in_last = l; in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
  endtask
  function automatic logic [15:0] r16();
    return 16'($urandom_range(1, 65535));
  endfunction
  initial begin
    logic [15:0] x0, x1, y1;
    int na, nd0;
    model_reset();
    @(negedge clk);
    cmp("reset");
    repeat (2) cyc();
    rst = 0;
    repeat (2) cyc();
    clr_log();
    drv(1, 0, 16'h3F80, 16'h4000, 16'h3F80, 16'h4000); cyc();
    drv(1, 1, 16'h3F80, 16'h4000, 16'h3F80, 16'h4000); cyc();
    drv(0, 0, 0, 0, 0, 0);
    repeat (8) cyc();
    chk("basic clear_acc count", 32'(nclr), 1);
    chk("basic clear_acc slot", 32'(lclr[1]), 1);
    chk("basic lane0 first", 32'(la0[2]), 32'h3F80);
    chk("basic lane0 second", 32'(la0[3]), 32'h3F80);
    chk("basic valid pair", 32'({lfv[2], lfv[3], lfv[4]}), 32'b110);
    chk("basic lane1 first", 32'(la1[3]), 32'h4000);
    chk("basic lane1 second", 32'(la1[4]), 32'h4000);
    chk("basic done slot", 32'(ldn[4]), 1);
    chk("basic done count", 32'(ndn), 1);
    clr_log();
    drv(1, 1, r16(), r16(), r16(), r16()); cyc();
    for (int i = 0; i < 5; i++) begin drv(1, i == 3, r16(), r16(), r16(), r16()); cyc(); end
    drv(0, 0, 0, 0, 0, 0);
    repeat (14) cyc();
    chk("stall ready before full", 32'(lrdy[3]), 1);
    chk("stall ready full", 32'(lrdy[4]), 0);
    chk("stall ready held", 32'(lrdy[5]), 0);
    chk("stall ready after pop", 32'(lrdy[6]), 1);
    chk("stall done count", 32'(ndn), 2);
    clr_log();
    x1 = r16(); y1 = r16();
    drv(1, 0, r16(), x1, r16(), r16()); cyc();
    drv(0, 0, 0, 0, 0, 0); repeat (3) cyc();
    drv(1, 1, r16(), y1, r16(), r16()); cyc();
    drv(0, 0, 0, 0, 0, 0); repeat (8) cyc();
    chk("gap valid pattern", 32'({lfv[2], lfv[3], lfv[4], lfv[5]}), 32'b1001);
    chk("gap lane0 bubble1", 32'(la0[3]), 0);
    chk("gap lane0 bubble2", 32'(la0[4]), 0);
    chk("gap lane1 first", 32'(la1[3]), 32'(x1));
    chk("gap lane1 bubble1", 32'(la1[4]), 0);
    chk("gap lane1 bubble2", 32'(la1[5]), 0);
    chk("gap lane1 last", 32'(la1[6]), 32'(y1));
    clr_log();
    drv(1, 1, r16(), r16(), r16(), r16()); cyc();
    for (int i = 0; i < 4; i++) begin drv(1, 0, r16(), r16(), r16(), r16()); cyc(); end
    drv(0, 0, 0, 0, 0, 0); repeat (2) cyc();
    chk("midrst feeding", 32'(lfv[6]), 1);
    chk("midrst queued", 32'(mq.size()), 3);
    nd0 = ndn;
    rst = 1;
    #1;
    model_reset();
    cmp("midrst async");
    repeat (2) cyc();
    rst = 0;
    repeat (6) cyc();
    chk("midrst no done", 32'(ndn), 32'(nd0));
    clr_log();
    x0 = r16(); x1 = r16();
    drv(1, 1, x0, x1, r16(), r16()); cyc();
    drv(0, 0, 0, 0, 0, 0); repeat (6) cyc();
    chk("single lane0", 32'(la0[2]), 32'(x0));
    chk("single live count", 32'(nfv), 1);
    chk("single done slot", 32'(ldn[3]), 1);
    chk("single lane1", 32'(la1[3]), 32'(x1));
    chk("single beat_count", 32'(lbc[3]), CNT_ON ? 32'd1 : 32'd0);
    clr_log();
    na = 0;
    for (int c = 0; c < 2000 && na < 300; c++) begin
      drv(1, na == 299, r16(), r16(), r16(), r16());
      cyc();
      if (acc) na++;
    end
    chk("long accepted", 32'(na), 300);
    drv(0, 0, 0, 0, 0, 0); repeat (12) cyc();
    chk("long beat_count", 32'(beat_count), CNT_ON ? 32'd255 : 32'd0);
    chk("long done count", 32'(ndn), 1);
    repeat (300) begin
      drv(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, r16(), r16(), r16(), r16());
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0); repeat (20) cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
